// File: rtl/mux_pkg.sv
// Shared definitions for the registered round-robin result multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of a channel index for n channels, never less than one bit.
    function automatic int sel_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_rr_reg_if.sv
// Channel-side and result-side handshake bundle of the multiplexer.
interface mux_rr_reg_if
    import mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 8
) ();
    localparam int SEL_W = sel_w(NUM_CH);

    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    // Producer/consumer side: drives requests and accepts results.
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Multiplexer side.
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_reg_arb.sv
// Round-robin arbiter: finds the first requester starting at ptr and
// moves ptr past the winner whenever the grant is actually taken.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int  NUM_CH = 8,
    localparam int SEL_W  = sel_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any_grant
);
    logic [SEL_W-1:0] ptr;

    // Scan offsets from farthest to nearest so the nearest requester wins;
    // the wrap is a conditional subtract, so non-power-of-2 NUM_CH works.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

    // Pointer moves to the channel after the taken grant, wrapping to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/mux_rr_reg.sv
// Registered N-channel result multiplexer with FIXED and round-robin
// selection and a one-entry output register for backpressure.
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  NUM_CH = 8,
    localparam int SEL_W  = sel_w(NUM_CH)
) (
    input logic        clk,
    input logic        rst_n,
    mux_rr_reg_if.slave bus
);
    logic              load_en;
    logic              rr_mode;
    logic              fixed_hit;
    logic              grant_any;
    logic              advance;
    logic              arb_any;
    logic [NUM_CH-1:0] arb_grant;
    logic [NUM_CH-1:0] fixed_onehot;
    logic [SEL_W-1:0]  arb_idx;
    logic [SEL_W-1:0]  gnt_idx;
    logic [WIDTH-1:0]  gnt_data;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.in_valid),
        .advance   (advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // Decode sel by comparison so an out-of-range value matches nothing.
    always_comb begin
        fixed_hit    = 1'b0;
        fixed_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                fixed_onehot[i] = 1'b1;
                fixed_hit       = bus.in_valid[i];
            end
        end
    end

    assign rr_mode   = (bus.mode == MODE_RR);
    assign load_en   = !bus.out_valid || bus.out_ready;
    // rst_n gates the grant so nothing is accepted while reset is held.
    assign grant_any = rst_n && load_en && (rr_mode ? arb_any : fixed_hit);
    assign gnt_idx   = rr_mode ? arb_idx : bus.sel;
    assign advance   = grant_any && rr_mode;
    assign bus.in_ready = grant_any ? (rr_mode ? arb_grant : fixed_onehot) : '0;

    // Select the granted channel's slice of the flat input bus.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) gnt_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output register: loads on a grant, empties when free with no grant,
    // holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
        end else if (load_en) begin
            bus.out_valid <= grant_any;
            if (grant_any) begin
                bus.out_data <= gnt_data;
                bus.out_ch   <= gnt_idx;
            end
        end
    end
endmodule
